// File: rtl/guard_pkg.sv
`timescale 1ns/1ps
// Shared guard definitions: direction codes seen by the sprite block, patrol legs and FSM states.
package guard_pkg;

    localparam logic [2:0] DIR_LEFT  = 3'b000;
    localparam logic [2:0] DIR_RIGHT = 3'b001;
    localparam logic [2:0] DIR_DOWN  = 3'b010;
    localparam logic [2:0] DIR_UP    = 3'b011;
    localparam logic [2:0] DIR_STOP  = 3'b111;

    typedef enum logic [1:0] {LEG_RIGHT, LEG_DOWN, LEG_LEFT, LEG_UP} leg_t;

    typedef enum logic [1:0] {IDLE, WALK, PAUSE} patrol_state_t;

    function automatic logic [2:0] leg_dir(input leg_t leg);
        case (leg)
            LEG_RIGHT: return DIR_RIGHT;
            LEG_DOWN:  return DIR_DOWN;
            LEG_LEFT:  return DIR_LEFT;
            default:   return DIR_UP;
        endcase
    endfunction

    // Patrol runs clockwise around the rectangle.
    function automatic leg_t next_leg(input leg_t leg);
        case (leg)
            LEG_RIGHT: return LEG_DOWN;
            LEG_DOWN:  return LEG_LEFT;
            LEG_LEFT:  return LEG_UP;
            default:   return LEG_RIGHT;
        endcase
    endfunction

endpackage

// File: rtl/guard_anim_div.sv
`timescale 1ns/1ps
// Walk-cycle divider: advances anim_phase once every ANIM_DIV enabled ticks; clear wins over tick.
module guard_anim_div #(
    parameter int ANIM_DIV = 8
) (
    input  logic       vga_clk,
    input  logic       Reset_n,
    input  logic       tick,
    input  logic       clear,
    output logic [1:0] anim_phase
);

    logic [7:0] div_cnt;

    always_ff @(posedge vga_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt    <= '0;
            anim_phase <= '0;
        end else if (clear) begin
            div_cnt    <= '0;
            anim_phase <= '0;
        end else if (tick) begin
            if (div_cnt == 8'(ANIM_DIV - 1)) begin
                div_cnt    <= '0;
                anim_phase <= anim_phase + 2'd1;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/guard_patrol_ctrl.sv
`timescale 1ns/1ps
// Guard patrol sequencer: walks a rectangular loop one step per frame with corner pauses.
module guard_patrol_ctrl
    import guard_pkg::*;
#(
    parameter logic [9:0] X_MIN        = 10'd100,
    parameter logic [9:0] X_MAX        = 10'd500,
    parameter logic [9:0] Y_MIN        = 10'd80,
    parameter logic [9:0] Y_MAX        = 10'd380,
    parameter int         STEP         = 2,
    parameter int         PAUSE_FRAMES = 30,
    parameter int         ANIM_DIV     = 8
) (
    input  logic       vga_clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic       freeze,
    output logic [9:0] GuardX,
    output logic [9:0] GuardY,
    output logic [2:0] direction_guard,
    output logic [1:0] anim_phase,
    output logic       corner
);

    patrol_state_t state_q, state_d;
    leg_t          leg_q, leg_d;
    logic [9:0]    x_d, y_d, new_coord;
    logic [7:0]    pause_cnt_q, pause_cnt_d;
    logic [2:0]    dir_d;
    logic          corner_d, walk_step, leg_end, anim_tick, anim_clear;
    logic          horiz, fwd, hit;
    logic [10:0]   cur, lim, cand;

    always_ff @(posedge vga_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q         <= IDLE;
            leg_q           <= LEG_RIGHT;
            GuardX          <= X_MIN;
            GuardY          <= Y_MIN;
            pause_cnt_q     <= '0;
            direction_guard <= DIR_STOP;
            corner          <= 1'b0;
        end else begin
            state_q         <= state_d;
            leg_q           <= leg_d;
            GuardX          <= x_d;
            GuardY          <= y_d;
            pause_cnt_q     <= pause_cnt_d;
            direction_guard <= dir_d;
            corner          <= corner_d;
        end
    end

    // Step math is 11 bits wide so a step past an edge clamps instead of wrapping.
    always_comb begin
        horiz = (leg_q == LEG_RIGHT) || (leg_q == LEG_LEFT);
        fwd   = (leg_q == LEG_RIGHT) || (leg_q == LEG_DOWN);
        cur   = horiz ? {1'b0, GuardX} : {1'b0, GuardY};
        case (leg_q)
            LEG_RIGHT: lim = {1'b0, X_MAX};
            LEG_DOWN:  lim = {1'b0, Y_MAX};
            LEG_LEFT:  lim = {1'b0, X_MIN};
            default:   lim = {1'b0, Y_MIN};
        endcase
        cand      = fwd ? cur + 11'(STEP) : cur - 11'(STEP);
        hit       = fwd ? (cand >= lim) : (cur <= lim + 11'(STEP));
        new_coord = hit ? lim[9:0] : cand[9:0];

        state_d     = state_q;
        leg_d       = leg_q;
        x_d         = GuardX;
        y_d         = GuardY;
        pause_cnt_d = pause_cnt_q;
        walk_step   = 1'b0;
        leg_end     = 1'b0;

        if (frame_tick) begin
            if (!enable) begin
                state_d     = IDLE;
                pause_cnt_d = '0;
            end else if (!freeze) begin
                case (state_q)
                    PAUSE: begin
                        pause_cnt_d = pause_cnt_q - 8'd1;
                        if (pause_cnt_q == 8'd1) state_d = WALK;
                    end
                    default: begin
                        walk_step = 1'b1;
                        if (horiz) x_d = new_coord;
                        else       y_d = new_coord;
                        if (hit) begin
                            leg_end     = 1'b1;
                            pause_cnt_d = 8'(PAUSE_FRAMES);
                            leg_d       = next_leg(leg_q);
                            state_d     = PAUSE;
                        end else begin
                            state_d = WALK;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        dir_d      = direction_guard;
        corner_d   = 1'b0;
        anim_tick  = 1'b0;
        anim_clear = 1'b0;
        if (frame_tick) begin
            corner_d   = leg_end;
            anim_clear = (state_d != WALK);
            anim_tick  = walk_step && !leg_end;
            dir_d      = (state_d == WALK && enable && !freeze) ? leg_dir(leg_d) : DIR_STOP;
        end
    end

    guard_anim_div #(.ANIM_DIV(ANIM_DIV)) u_anim_div (
        .vga_clk    (vga_clk),
        .Reset_n    (Reset_n),
        .tick       (anim_tick),
        .clear      (anim_clear),
        .anim_phase (anim_phase)
    );

endmodule

// File: tb/tb_guard_patrol_ctrl.sv
`timescale 1ns/1ps
// Bench for guard_patrol_ctrl: a per-tick reference model feeds an expected-output queue.
module tb_guard_patrol_ctrl;

    localparam int XMIN = 100, XMAX = 500, YMIN = 80, YMAX = 380;
    localparam int STEP = 2, PAUSE = 30, ADIV = 8;

    logic       vga_clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       enable = 1'b0;
    logic       freeze = 1'b0;
    logic [9:0] GuardX, GuardY, clampX, clampY;
    logic [2:0] direction_guard, clampDir;
    logic [1:0] anim_phase, clampPhase;
    logic       corner, clampCorner;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] dir;
        logic [1:0] phase;
        logic       corner;
    } obs_t;

    obs_t expQ[$];
    obs_t got, want;
    int   passed = 0;
    int   total = 0;

    int mState, mLeg, mX, mY, mCnt, mDiv, mPhase, mDir, mCorner;

    always #5 vga_clk = ~vga_clk;

    guard_patrol_ctrl dut (
        .vga_clk(vga_clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
        .enable(enable), .freeze(freeze), .GuardX(GuardX), .GuardY(GuardY),
        .direction_guard(direction_guard), .anim_phase(anim_phase), .corner(corner)
    );

    guard_patrol_ctrl #(.X_MAX(10'd499)) dut_clamp (
        .vga_clk(vga_clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
        .enable(enable), .freeze(freeze), .GuardX(clampX), .GuardY(clampY),
        .direction_guard(clampDir), .anim_phase(clampPhase), .corner(clampCorner)
    );

    function automatic obs_t observed();
        return '{x: GuardX, y: GuardY, dir: direction_guard, phase: anim_phase, corner: corner};
    endfunction

    function automatic int dirOf(input int leg);
        case (leg)
            0: return 1;
            1: return 2;
            2: return 0;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        mState = 0; mLeg = 0; mX = XMIN; mY = YMIN; mCnt = 0;
        mDiv = 0; mPhase = 0; mDir = 7; mCorner = 0;
        expQ.delete();
    endtask

    // One frame of the reference patrol, using the enable/freeze currently driven.
    task automatic model_step();
        int pos, lim;
        bit reached;
        mCorner = 0;
        if (!enable) begin
            mState = 0; mDiv = 0; mPhase = 0; mDir = 7;
        end else if (freeze) begin
            mDir = 7;
        end else if (mState == 2) begin
            mCnt = mCnt - 1;
            if (mCnt == 0) begin mState = 1; mDir = dirOf(mLeg); end
            else mDir = 7;
        end else begin
            case (mLeg)
                0: begin pos = mX + STEP; lim = XMAX; reached = (pos >= lim); end
                1: begin pos = mY + STEP; lim = YMAX; reached = (pos >= lim); end
                2: begin pos = mX - STEP; lim = XMIN; reached = (pos <= lim); end
                default: begin pos = mY - STEP; lim = YMIN; reached = (pos <= lim); end
            endcase
            if (reached) pos = lim;
            if (mLeg == 0 || mLeg == 2) mX = pos; else mY = pos;
            if (reached) begin
                mCorner = 1; mCnt = PAUSE; mState = 2; mDiv = 0; mPhase = 0; mDir = 7;
                mLeg = (mLeg + 1) % 4;
            end else begin
                mState = 1; mDir = dirOf(mLeg);
                mDiv = mDiv + 1;
                if (mDiv == ADIV) begin mDiv = 0; mPhase = (mPhase + 1) % 4; end
            end
        end
        expQ.push_back('{x: 10'(mX), y: 10'(mY), dir: 3'(mDir), phase: 2'(mPhase), corner: 1'(mCorner)});
    endtask

    // One frame_tick pulse with a quiet clock cycle before it; returns #1 after the tick edge.
    task automatic tick();
        repeat (2) @(negedge vga_clk);
        frame_tick = 1'b1;
        model_step();
        @(posedge vga_clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge vga_clk);
        Reset_n = 1'b0; enable = 1'b0; freeze = 1'b0;
        model_reset();
        repeat (2) @(negedge vga_clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        got = observed();
        want = '{x: 10'd100, y: 10'd80, dir: 3'b111, phase: 2'd0, corner: 1'b0};
        total++;
        if (got !== want) $display("[TB] FAIL reset_values got=%h want=%h", got, want);
        else passed++;
    endtask

    task automatic test_first_leg();
        do_reset();
        enable = 1'b1;
        for (int i = 1; i <= 231; i++) begin
            tick();
            got = observed(); want = expQ.pop_front();
            total++;
            if (got !== want) $display("[TB] FAIL leg_sb tick%0d got=%h want=%h", i, got, want);
            else passed++;
            if (i == 1) begin
                total++;
                if (GuardX !== 10'd102 || GuardY !== 10'd80 || direction_guard !== 3'b001 || corner !== 1'b0)
                    $display("[TB] FAIL first_step got x=%0d y=%0d dir=%b c=%b want 102 80 001 0",
                             GuardX, GuardY, direction_guard, corner);
                else passed++;
            end
            if (i == 199) begin
                total++;
                if (clampX !== 10'd498) $display("[TB] FAIL clamp_pre got=%0d want=498", clampX);
                else passed++;
            end
            if (i == 200) begin
                total++;
                if (GuardX !== 10'd500 || corner !== 1'b1 || direction_guard !== 3'b111)
                    $display("[TB] FAIL leg_end got x=%0d c=%b dir=%b want 500 1 111", GuardX, corner, direction_guard);
                else passed++;
                total++;
                if (clampX !== 10'd499 || clampCorner !== 1'b1)
                    $display("[TB] FAIL clamp_499 got x=%0d c=%b want 499 1", clampX, clampCorner);
                else passed++;
                @(posedge vga_clk); #1;
                total++;
                if (corner !== 1'b0) $display("[TB] FAIL corner_pulse got=%b want=0", corner);
                else passed++;
            end
            if (i == 231) begin
                total++;
                if (GuardY !== 10'd82 || GuardX !== 10'd500 || direction_guard !== 3'b010)
                    $display("[TB] FAIL down_start got x=%0d y=%0d dir=%b want 500 82 010", GuardX, GuardY, direction_guard);
                else passed++;
            end
        end
    endtask

    task automatic test_full_loop();
        int cornX[4] = '{500, 500, 100, 100};
        int cornY[4] = '{80, 380, 380, 80};
        int found = 0;
        int budget = 0;
        do_reset();
        enable = 1'b1;
        while (found < 4 && budget < 1000) begin
            tick();
            budget++;
            got = observed(); want = expQ.pop_front();
            total++;
            if (got !== want) $display("[TB] FAIL loop_sb tick%0d got=%h want=%h", budget, got, want);
            else passed++;
            if (corner === 1'b1) begin
                total++;
                if (GuardX !== 10'(cornX[found]) || GuardY !== 10'(cornY[found]))
                    $display("[TB] FAIL loop_corner%0d got=(%0d,%0d) want=(%0d,%0d)",
                             found, GuardX, GuardY, cornX[found], cornY[found]);
                else passed++;
                found++;
            end
        end
        if (found < 4) begin
            total++;
            $display("[TB] FAIL loop_budget got corners=%0d want=4", found);
        end
        for (int i = 0; i < 31; i++) begin
            tick();
            void'(expQ.pop_front());
        end
        total++;
        if (GuardX !== 10'd102 || GuardY !== 10'd80 || direction_guard !== 3'b001)
            $display("[TB] FAIL loop_restart got x=%0d y=%0d dir=%b want 102 80 001", GuardX, GuardY, direction_guard);
        else passed++;
    endtask

    task automatic test_freeze();
        int heldPhase;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            got = observed(); want = expQ.pop_front();
            total++;
            if (got !== want) $display("[TB] FAIL frz_pre_sb got=%h want=%h", got, want);
            else passed++;
        end
        total++;
        if (GuardX !== 10'd300) $display("[TB] FAIL frz_start got x=%0d want=300", GuardX);
        else passed++;
        heldPhase = mPhase;
        freeze = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            got = observed(); want = expQ.pop_front();
            total++;
            if (got !== want || GuardX !== 10'd300 || direction_guard !== 3'b111 || anim_phase !== 2'(heldPhase))
                $display("[TB] FAIL frz_hold got=%h want=%h", got, want);
            else passed++;
        end
        freeze = 1'b0;
        tick();
        void'(expQ.pop_front());
        total++;
        if (GuardX !== 10'd302 || direction_guard !== 3'b001)
            $display("[TB] FAIL frz_release got x=%0d dir=%b want 302 001", GuardX, direction_guard);
        else passed++;
        repeat (3) begin tick(); void'(expQ.pop_front()); end
        total++;
        if (anim_phase !== 2'd1) $display("[TB] FAIL frz_phase_cont got=%0d want=1", anim_phase);
        else passed++;
    endtask

    task automatic test_enable_pause();
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 205; i++) begin
            tick();
            got = observed(); want = expQ.pop_front();
            total++;
            if (got !== want) $display("[TB] FAIL en_pre_sb got=%h want=%h", got, want);
            else passed++;
        end
        enable = 1'b0;
        tick();
        got = observed(); want = expQ.pop_front();
        total++;
        if (got !== want || direction_guard !== 3'b111 || GuardX !== 10'd500 || GuardY !== 10'd80)
            $display("[TB] FAIL en_idle got=%h want=%h", got, want);
        else passed++;
        enable = 1'b1;
        tick();
        got = observed(); want = expQ.pop_front();
        total++;
        if (got !== want || GuardY !== 10'd82 || direction_guard !== 3'b010)
            $display("[TB] FAIL en_resume got=%h want=%h", got, want);
        else passed++;
        enable = 1'b0; freeze = 1'b1;
        tick();
        got = observed(); want = expQ.pop_front();
        total++;
        if (got !== want || direction_guard !== 3'b111 || GuardY !== 10'd82)
            $display("[TB] FAIL en_over_freeze got=%h want=%h", got, want);
        else passed++;
        enable = 1'b1; freeze = 1'b0;
        tick();
        got = observed(); want = expQ.pop_front();
        total++;
        if (got !== want || GuardY !== 10'd84)
            $display("[TB] FAIL en_rewalk got=%h want=%h", got, want);
        else passed++;
    endtask

    task automatic test_anim();
        do_reset();
        enable = 1'b1;
        for (int i = 1; i <= 205; i++) begin
            tick();
            got = observed(); want = expQ.pop_front();
            total++;
            if (got !== want) $display("[TB] FAIL anim_sb tick%0d got=%h want=%h", i, got, want);
            else passed++;
            if (i <= 32 && (i % 8 == 0 || i % 8 == 7)) begin
                total++;
                if (anim_phase !== 2'((i / 8) % 4))
                    $display("[TB] FAIL anim_tick%0d got=%0d want=%0d", i, anim_phase, (i / 8) % 4);
                else passed++;
            end
            if (i >= 200) begin
                total++;
                if (anim_phase !== 2'd0) $display("[TB] FAIL anim_pause got=%0d want=0", anim_phase);
                else passed++;
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            void'(expQ.pop_front());
        end
        @(posedge vga_clk);
        #3;
        Reset_n = 1'b0;
        #1;
        got = observed();
        want = '{x: 10'd100, y: 10'd80, dir: 3'b111, phase: 2'd0, corner: 1'b0};
        total++;
        if (got !== want) $display("[TB] FAIL async_reset got=%h want=%h", got, want);
        else passed++;
        model_reset();
        @(negedge vga_clk);
        Reset_n = 1'b1;
        tick();
        got = observed(); want = expQ.pop_front();
        total++;
        if (got !== want || GuardX !== 10'd102) $display("[TB] FAIL post_reset got=%h want=%h", got, want);
        else passed++;
    endtask

    initial begin
        #900_000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_first_leg();
        test_full_loop();
        test_freeze();
        test_enable_pause();
        test_anim();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/guard_patrol_ctrl.md
Name: guard_patrol_ctrl

Overview:
- Sequences one guard around a rectangular patrol loop: right, pause, down, pause, left, pause, up, pause, repeat.
- Produces GuardX/GuardY (sprite top-left) and direction_guard for the guard walk-animation/sprite block.
- Produces anim_phase, the frame-synchronous walk phase used by sprite-frame selection.
- Sits between the frame timing logic (frame_tick) and the guard sprite renderer; all motion is stepped once per video frame.

Parameters:
- X_MIN, 10'd100: left patrol edge (pixels).
- X_MAX, 10'd500: right patrol edge; must be > X_MIN.
- Y_MIN, 10'd80: top patrol edge.
- Y_MAX, 10'd380: bottom patrol edge; must be > Y_MIN.
- STEP, 2: pixels moved per frame_tick while walking; range 1..15.
- PAUSE_FRAMES, 30: frame_ticks spent stationary at each corner; range 1..255.
- ANIM_DIV, 8: frame_ticks per anim_phase increment; range 1..255.

Ports:
- vga_clk, input, 1: pixel clock; the only clock.
- Reset_n, input, 1: asynchronous, active-low reset.
- frame_tick, input, 1: one-cycle pulse per frame (start of vertical blank).
- enable, input, 1: patrol run; when low, the guard parks.
- freeze, input, 1: hold the guard in place (player caught or game paused).
- GuardX, output, 10: guard X position.
- GuardY, output, 10: guard Y position.
- direction_guard, output, 3: 000 left, 001 right, 010 down, 011 up, 111 stationary.
- anim_phase, output, 2: walk-cycle phase.
- corner, output, 1: one-cycle pulse when a leg ends.

Behaviour:
- Reset (async, Reset_n=0):
  - GuardX=X_MIN, GuardY=Y_MIN.
  - State IDLE, leg register=RIGHT.
  - direction_guard=111, anim_phase=0, corner=0.
  - Pause counter and anim divider cleared.
- Update timing:
  - All state, position and output registers change only in a vga_clk cycle where frame_tick=1. The exception is corner, which clears on the next cycle.
  - Outputs are registered. A new position is visible one vga_clk cycle after the tick edge.
- States: IDLE, WALK, PAUSE. The leg register holds RIGHT, DOWN, LEFT or UP.
- IDLE:
  - direction_guard=111, anim_phase=0.
  - On a tick with enable=1 and freeze=0: go to WALK using the stored leg.
- WALK:
  - direction_guard=encoding of the current leg.
  - On each tick, compute the next coordinate in 11-bit arithmetic (no 10-bit wrap): RIGHT X+STEP, DOWN Y+STEP, LEFT X-STEP, UP Y-STEP.
  - If the result reaches or passes the leg limit (X_MAX, Y_MAX, X_MIN, Y_MIN respectively):
    - Clamp the coordinate exactly to the limit.
    - Pulse corner.
    - Load the pause counter with PAUSE_FRAMES.
    - Advance the leg clockwise (RIGHT to DOWN to LEFT to UP to RIGHT).
    - Go to PAUSE.
  - Otherwise take the new coordinate.
  - The non-moving coordinate never changes.
- PAUSE:
  - direction_guard=111, anim_phase=0.
  - On each tick, decrement the counter. The tick that decrements it from 1 to 0 returns the block to WALK on the new leg; movement starts on the following tick.
  - PAUSE therefore lasts exactly PAUSE_FRAMES ticks.
- anim_phase:
  - In WALK, a divider counts ticks; every ANIM_DIV ticks anim_phase increments, wrapping 3 to 0.
  - Leaving WALK clears both the divider and anim_phase.
- enable low:
  - On a tick with enable=0, go to IDLE from any state. Position and leg are kept.
  - A pause in progress is abandoned.
  - Re-enable resumes WALK on the stored leg.
- freeze:
  - On a tick with freeze=1 and enable=1: state, position, pause counter and anim divider all hold. direction_guard=111.
  - When freeze drops, the block resumes exactly where it stopped.
  - enable=0 has priority over freeze.
- Simultaneous events: a tick that reaches the limit produces clamp, corner and the PAUSE transition in the same update; no extra step occurs.
- Reset mid-leg or mid-pause returns to the reset values immediately, regardless of the clock.

Decomposition:
- Shared package guard_pkg holds:
  - the direction encoding constants DIR_LEFT/RIGHT/DOWN/UP/STOP (used by the sprite block too);
  - the leg_t typedef;
  - the patrol_state_t typedef (IDLE, WALK, PAUSE).
- One sub-module, guard_anim_div: tick-enabled divider with clear, outputting anim_phase.

Test Plan:
- Reset, enable=1, STEP=2, X_MIN=100, X_MAX=500, 1 tick -> GuardX=102, GuardY=80, direction=001, corner=0.
- Run 200 ticks -> GuardX=500 on tick 200, corner pulses exactly one cycle, direction=111. After 30 more ticks, next tick gives direction=010 and GuardY=82.
- Full loop with defaults -> positions pass (500,80), (500,380), (100,380), back to (100,80), then restart RIGHT. X_MAX=499 with STEP=2 -> clamps to 499, never 500.
- freeze=1 for 10 ticks mid-leg at X=300 -> X stays 300, direction=111, anim_phase held. After release, next tick gives X=302 with the prior phase continuing.
- enable=0 mid-pause, then enable=1 -> IDLE (direction=111), then WALK on the new leg immediately with no remaining pause. Both enable=0 and freeze=1 -> IDLE.
- ANIM_DIV=8 in WALK -> anim_phase goes 0,1,2,3,0 at ticks 8,16,24,32. Entering PAUSE forces 0. Asserting Reset_n=0 between clock edges -> outputs return to reset values asynchronously.
